// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdivinv_func_pkg.sv
// Shared constants for the multi-channel clock divider/inverter.
// No ports. Holds the default channel count and divider field width used
// by the top level and by the per-channel sub-module.
package gf180mcu_fd_sc_mcu9t5v0__clkdivinv_func_pkg;

    // Number of independent divider channels.
    localparam int unsigned CH_DEFAULT = 2;

    // Divider field width per channel; half-period is DIV+1 source cycles.
    localparam int unsigned DW_DEFAULT = 4;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdivinv_ch.sv
// One divider/inverter channel: produces a 50%-duty divided clock with
// programmable ratio, polarity and glitch-free start/stop.
// Ports:
//   CLK  - source clock, all state on rising edge
//   RN   - asynchronous active-low reset
//   EN   - run request
//   DIV  - half-period minus one
//   INV  - polarity (0: ZN idles high, 1: ZN idles low)
//   ZN   - divided clock, flop-driven
//   TC   - one-cycle pulse on every ZN toggle
//   BUSY - running or finishing the high phase
module gf180mcu_fd_sc_mcu9t5v0__clkdivinv_ch
    import gf180mcu_fd_sc_mcu9t5v0__clkdivinv_func_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RN,
    input  logic          EN,
    input  logic [DW-1:0] DIV,
    input  logic          INV,
    output logic          ZN,
    output logic          TC,
    output logic          BUSY
);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] div_act_q, div_act_d;
    logic          q_q, q_d;
    logic          inv_act_q, inv_act_d;
    logic          run_q, run_d;
    logic          zn_q, zn_d;
    logic          tc_q, tc_d;
    logic          busy_q, busy_d;

    logic          idle;
    logic [DW-1:0] div_eff;
    logic          hit;

    assign idle    = !run_q && !q_q;
    // While idle the ratio is reloaded every edge, so the start edge compares
    // against the value being loaded rather than last cycle's copy.
    assign div_eff = idle ? DIV : div_act_q;
    assign hit     = (cnt_q == div_eff);

    always_comb begin
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        q_d       = q_q;
        inv_act_d = inv_act_q;
        run_d     = run_q;
        tc_d      = 1'b0;

        if (idle) begin
            div_act_d = DIV;
            inv_act_d = INV;
            cnt_d     = '0;
            if (EN) begin
                // Start edge is also the first counting edge.
                run_d = 1'b1;
                if (hit) begin
                    q_d  = 1'b1;
                    tc_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
        end else if (!q_q && !EN) begin
            // Stop during the low phase: no toggle, so no runt pulse.
            run_d = 1'b0;
            cnt_d = '0;
        end else begin
            if (hit) begin
                cnt_d = '0;
                q_d   = ~q_q;
                tc_d  = 1'b1;
                if (q_q) begin
                    // 1->0 toggle is the period boundary: reload settings and
                    // either keep running or drop to idle.
                    div_act_d = DIV;
                    inv_act_d = INV;
                    run_d     = EN;
                end
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    // Outputs are registered from next-state values so polarity and phase
    // changing on the same edge cannot produce a glitch.
    always_comb begin
        zn_d   = ~(q_d ^ inv_act_d);
        busy_d = run_d | q_d;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt_q     <= '0;
            div_act_q <= '0;
            q_q       <= 1'b0;
            inv_act_q <= 1'b0;
            run_q     <= 1'b0;
            zn_q      <= 1'b1;
            tc_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            q_q       <= q_d;
            inv_act_q <= inv_act_d;
            run_q     <= run_d;
            zn_q      <= zn_d;
            tc_q      <= tc_d;
            busy_q    <= busy_d;
        end
    end

    assign ZN   = zn_q;
    assign TC   = tc_q;
    assign BUSY = busy_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdivinv_func.sv
// Multi-channel clock divider/inverter. Instantiates CH independent
// channels and slices the packed buses.
// Ports:
//   CLK  - source clock
//   RN   - asynchronous active-low reset
//   EN   - per-channel run request [CH]
//   DIV  - per-channel half-period minus one, DW bits each [CH*DW]
//   INV  - per-channel polarity [CH]
//   ZN   - divided clocks [CH]
//   TC   - toggle pulses [CH]
//   BUSY - per-channel busy [CH]
module gf180mcu_fd_sc_mcu9t5v0__clkdivinv_func
    import gf180mcu_fd_sc_mcu9t5v0__clkdivinv_func_pkg::*;
#(
    parameter int unsigned CH = CH_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [CH-1:0]    EN,
    input  logic [CH*DW-1:0] DIV,
    input  logic [CH-1:0]    INV,
    output logic [CH-1:0]    ZN,
    output logic [CH-1:0]    TC,
    output logic [CH-1:0]    BUSY
);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        gf180mcu_fd_sc_mcu9t5v0__clkdivinv_ch #(
            .DW (DW)
        ) u_ch (
            .CLK  (CLK),
            .RN   (RN),
            .EN   (EN[c]),
            .DIV  (DIV[c*DW +: DW]),
            .INV  (INV[c]),
            .ZN   (ZN[c]),
            .TC   (TC[c]),
            .BUSY (BUSY[c])
        );
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdivinv_func.sv
// Scoreboard bench: the driver applies inputs on the falling edge, runs a
// waveform-level reference model and queues the expected outputs; a monitor
// compares them just after each rising edge.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdivinv_func;

    localparam int CH = 2;
    localparam int DW = 4;
    localparam int WMAX = 2 ** (DW + 1);

    typedef struct packed {
        logic [CH-1:0] zn;
        logic [CH-1:0] tc;
        logic [CH-1:0] busy;
    } exp_t;

    logic             CLK;
    logic             RN;
    logic [CH-1:0]    EN;
    logic [CH*DW-1:0] DIV;
    logic [CH-1:0]    INV;
    logic [CH-1:0]    ZN;
    logic [CH-1:0]    TC;
    logic [CH-1:0]    BUSY;

    int checks;
    int failures;
    exp_t sbq[$];

    gf180mcu_fd_sc_mcu9t5v0__clkdivinv_func #(
        .CH (CH),
        .DW (DW)
    ) dut (
        .CLK  (CLK),
        .RN   (RN),
        .EN   (EN),
        .DIV  (DIV),
        .INV  (INV),
        .ZN   (ZN),
        .TC   (TC),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: each period is generated as a whole waveform of the
    // internal phase (DIV low samples, DIV+1 high samples, one boundary low)
    // and consumed one sample per clock.
    bit wave [CH][WMAX];
    int wlen [CH];
    int wpos [CH];
    bit m_run [CH];
    bit m_q [CH];
    bit m_pol [CH];
    int m_div [CH];

    function automatic void build(input int c, input int d);
        for (int i = 0; i < 2 * d + 2; i++) wave[c][i] = (i >= d) && (i < 2 * d + 1);
        wlen[c] = 2 * d + 2;
        wpos[c] = 0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 0; m_q[c] = 0; m_pol[c] = 0; m_div[c] = 0;
            wlen[c] = 0; wpos[c] = 0;
        end
    endfunction

    function automatic exp_t model_step(input logic [CH-1:0] en, input logic [CH*DW-1:0] div,
                                        input logic [CH-1:0] inv);
        exp_t e;
        for (int c = 0; c < CH; c++) begin
            int d;
            bit qb;
            bit adv;
            d   = int'(div[c*DW +: DW]);
            qb  = m_q[c];
            adv = 0;
            if (!m_run[c] && !m_q[c]) begin
                m_pol[c] = inv[c];
                if (en[c]) begin
                    build(c, d);
                    m_run[c] = 1;
                    adv = 1;
                end
            end else if (!m_q[c] && !en[c]) begin
                m_run[c] = 0;
                wlen[c] = 0;
                wpos[c] = 0;
            end else begin
                if (wpos[c] == wlen[c]) build(c, m_div[c]);
                adv = 1;
            end
            if (adv) begin
                m_q[c] = wave[c][wpos[c]];
                wpos[c]++;
                if (wpos[c] == wlen[c]) begin
                    m_div[c] = d;
                    m_pol[c] = inv[c];
                    m_run[c] = en[c];
                end
            end
            e.zn[c]   = ~(m_q[c] ^ m_pol[c]);
            e.tc[c]   = adv && (m_q[c] != qb);
            e.busy[c] = m_run[c] | m_q[c];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [CH-1:0] en, input logic [CH*DW-1:0] div,
                        input logic [CH-1:0] inv);
        EN  = en;
        DIV = div;
        INV = inv;
        sbq.push_back(model_step(en, div, inv));
        @(negedge CLK);
    endtask

    task automatic steps(input int n, input logic [CH-1:0] en, input logic [CH*DW-1:0] div,
                         input logic [CH-1:0] inv);
        for (int i = 0; i < n; i++) step(en, div, inv);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("zn", 8'(ZN), 8'(e.zn));
                check("tc", 8'(TC), 8'(e.tc));
                check("busy", 8'(BUSY), 8'(e.busy));
            end
        end
    end

    logic [CH-1:0]    en_r;
    logic [CH*DW-1:0] div_r;
    logic [CH-1:0]    inv_r;

    initial begin
        checks = 0;
        failures = 0;
        model_reset();

        // Reset with random inputs.
        RN  = 1'b0;
        EN  = CH'($urandom);
        DIV = (CH*DW)'($urandom);
        INV = CH'($urandom);
        #12;
        check("rst_zn", 8'(ZN), 8'h03);
        check("rst_tc", 8'(TC), 8'h00);
        check("rst_busy", 8'(BUSY), 8'h00);

        @(negedge CLK);
        RN = 1'b1;
        steps(2, 2'b00, 8'h00, 2'b10);   // ZN becomes 2'b01

        // CLK/2 on ch0.
        steps(8, 2'b01, 8'h00, 2'b00);
        steps(4, 2'b00, 8'h00, 2'b00);

        // CLK/6, ratio changed to 1 during the high phase.
        steps(4, 2'b01, 8'h02, 2'b00);
        steps(12, 2'b01, 8'h01, 2'b00);
        steps(6, 2'b00, 8'h01, 2'b00);

        // Glitch-free stop one cycle into the high phase.
        steps(5, 2'b01, 8'h03, 2'b00);
        steps(8, 2'b00, 8'h03, 2'b00);
        // Same, but EN comes back during the high phase.
        steps(5, 2'b01, 8'h03, 2'b00);
        steps(1, 2'b00, 8'h03, 2'b00);
        steps(12, 2'b01, 8'h03, 2'b00);
        steps(10, 2'b00, 8'h03, 2'b00);

        // Polarity flips mid-period on ch1.
        steps(5, 2'b10, 8'h10, 2'b00);
        steps(10, 2'b10, 8'h10, 2'b10);
        steps(7, 2'b10, 8'h10, 2'b00);
        steps(8, 2'b00, 8'h10, 2'b00);

        // Independent channels, then asynchronous reset mid-cycle.
        steps(9, 2'b11, 8'h50, 2'b00);
        #2;
        RN = 1'b0;
        #1;
        check("arst_zn", 8'(ZN), 8'h03);
        check("arst_tc", 8'(TC), 8'h00);
        check("arst_busy", 8'(BUSY), 8'h00);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RN = 1'b1;
        steps(16, 2'b11, 8'h50, 2'b00);
        steps(14, 2'b00, 8'h50, 2'b00);

        // Randomized run.
        en_r  = '0;
        div_r = '0;
        inv_r = '0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(9) == 0) en_r[c] = ~en_r[c];
                if ($urandom_range(5) == 0)
                    div_r[c*DW +: DW] = ($urandom_range(7) == 0) ? DW'($urandom_range(15))
                                                                 : DW'($urandom_range(3));
                if ($urandom_range(15) == 0) inv_r[c] = ~inv_r[c];
            end
            step(en_r, div_r, inv_r);
        end

        @(negedge CLK);
        check("sb_drained", 8'(sbq.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
